// File: rtl/acc_alu_pkg.sv
// Shared opcode constants and FSM state type for the accumulating ALU.
package acc_alu_pkg;

   localparam logic [2:0] OP_INC    = 3'b000;
   localparam logic [2:0] OP_ADDC   = 3'b001;
   localparam logic [2:0] OP_ADD    = 3'b010;
   localparam logic [2:0] OP_XOR_OR = 3'b011;
   localparam logic [2:0] OP_RED    = 3'b100;
   localparam logic [2:0] OP_SHL    = 3'b101;
   localparam logic [2:0] OP_SHR    = 3'b110;
   localparam logic [2:0] OP_MUL    = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/acc_alu_if.sv
// Operand/command and status bundle between a controller and acc_alu.
interface acc_alu_if #(
   parameter int unsigned W = 4
);
   logic [W-1:0]   a;
   logic [2:0]     f;
   logic           go;
   logic           clr;
   logic [2*W-1:0] acc;
   logic           busy;
   logic           done;
   logic           carry;
   logic           zero;

   modport master (
      output a, f, go, clr,
      input  acc, busy, done, carry, zero
   );

   modport slave (
      input  a, f, go, clr,
      output acc, busy, done, carry, zero
   );
endinterface

// File: rtl/acc_alu_mul.sv
// W-bit shift-add multiplier: one multiplier bit per cycle, LSB first.
module acc_alu_mul #(
   parameter int unsigned W = 4
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           start,
   input  logic [W-1:0]   mcand,
   input  logic [W-1:0]   mplier,
   output logic [2*W-1:0] prod,
   output logic           last
);

   localparam int unsigned CW = $clog2(W) + 1;

   logic [2*W-1:0] mcand_q;
   logic [2*W-1:0] partial_q;
   logic [W-1:0]   mplier_q;
   logic [CW-1:0]  cnt_q;
   logic           active_q;
   logic [2*W-1:0] step;

   // prod includes the current bit so the final edge can write it directly.
   assign step = mplier_q[0] ? mcand_q : '0;
   assign prod = partial_q + step;
   assign last = active_q && (cnt_q == CW'(W - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mcand_q   <= '0;
         partial_q <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         active_q  <= 1'b0;
      end else if (start) begin
         mcand_q   <= {{W{1'b0}}, mcand};
         partial_q <= '0;
         mplier_q  <= mplier;
         cnt_q     <= '0;
         active_q  <= 1'b1;
      end else if (active_q) begin
         partial_q <= prod;
         mcand_q   <= mcand_q << 1;
         mplier_q  <= mplier_q >> 1;
         cnt_q     <= cnt_q + CW'(1);
         if (last) begin
            active_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/acc_alu.sv
// Accumulating ALU with go/busy/done handshake; B operand is acc[W-1:0].
// Define ACC_ALU_MUL_EN to enable the multi-cycle multiply for op 111.
module acc_alu
   import acc_alu_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input logic     clock,
   input logic     reset_n,
   acc_alu_if.slave bus
);

   logic [W-1:0]   b;
   logic [W:0]     sum_ab;
   logic [W:0]     sum_inc;
   logic [2*W-1:0] acc_q, acc_d, res_acc;
   logic           carry_q, carry_d, res_carry;
   logic           done_q, done_d;
   logic           idle;

   assign b       = acc_q[W-1:0];
   assign sum_ab  = {1'b0, bus.a} + {1'b0, b};
   assign sum_inc = {1'b0, bus.a} + {{W{1'b0}}, 1'b1};

   always_comb begin
      res_acc   = acc_q;
      res_carry = carry_q;
      unique case (bus.f)
         OP_INC: begin
            res_acc   = {{(W-1){1'b0}}, sum_inc};
            res_carry = sum_inc[W];
         end
         OP_ADDC: begin
            res_acc   = {{(W-1){1'b0}}, sum_ab};
            res_carry = sum_ab[W];
         end
         OP_ADD:    res_acc = {{W{1'b0}}, sum_ab[W-1:0]};
         OP_XOR_OR: res_acc = {bus.a | b, bus.a ^ b};
         OP_RED:    res_acc = {{(2*W-1){1'b0}}, (|bus.a) | (|b)};
         OP_SHL:    res_acc = {{W{1'b0}}, b} << bus.a;
         OP_SHR:    res_acc = {{W{1'b0}}, b >> bus.a};
         OP_MUL:    res_acc = acc_q;
      endcase
   end

`ifdef ACC_ALU_MUL_EN
   state_e         state_q, state_d;
   logic           mul_start;
   logic           mul_last;
   logic [2*W-1:0] mul_prod;

   assign idle = (state_q == ST_IDLE);

   acc_alu_mul #(.W(W)) u_mul (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (mul_start),
      .mcand   (bus.a),
      .mplier  (b),
      .prod    (mul_prod),
      .last    (mul_last)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end
`else
   assign idle = 1'b1;
`endif

   always_comb begin
      acc_d   = acc_q;
      carry_d = carry_q;
      done_d  = 1'b0;
`ifdef ACC_ALU_MUL_EN
      state_d   = state_q;
      mul_start = 1'b0;
`endif
      if (idle) begin
         if (bus.clr) begin
            acc_d   = '0;
            carry_d = 1'b0;
         end else if (bus.go) begin
            acc_d   = res_acc;
            carry_d = res_carry;
            done_d  = 1'b1;
`ifdef ACC_ALU_MUL_EN
            // Multiply defers done to the final iteration; acc holds until then.
            if (bus.f == OP_MUL) begin
               done_d    = 1'b0;
               mul_start = 1'b1;
               state_d   = ST_MUL;
            end
`endif
         end
      end
`ifdef ACC_ALU_MUL_EN
      else if (mul_last) begin
         acc_d   = mul_prod;
         done_d  = 1'b1;
         state_d = ST_IDLE;
      end
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         carry_q <= carry_d;
         done_q  <= done_d;
      end
   end

   assign bus.acc   = acc_q;
   assign bus.carry = carry_q;
   assign bus.done  = done_q;
   assign bus.busy  = ~idle;
   assign bus.zero  = (acc_q == '0);

endmodule

// File: tb/tb_acc_alu.sv
// Scoreboard bench for acc_alu (W=4); expectations follow ACC_ALU_MUL_EN.
module tb_acc_alu;
   import acc_alu_pkg::*;

   localparam int unsigned W = 4;

`ifdef ACC_ALU_MUL_EN
   localparam int MUL_BUSY = 4;
   localparam int DONE_IDX = 4;
`else
   localparam int MUL_BUSY = 0;
   localparam int DONE_IDX = 0;
`endif

   typedef struct {
      logic [2*W-1:0] acc;
      logic           carry;
   } exp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   acc_alu_if #(.W(W)) bus ();

   acc_alu #(.W(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (reset_n && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: done=1 with no operation outstanding, required 0");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_acc", 32'(bus.acc), 32'(e.acc));
            chk("sb_carry", 32'(bus.carry), 32'(e.carry));
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic push,
                        input logic [2*W-1:0] eacc, input logic ecarry);
      exp_t e;
      bus.go = 1'b1;
      bus.f  = op;
      bus.a  = av;
      if (push) begin
         e.acc   = eacc;
         e.carry = ecarry;
         sb.push_back(e);
      end
      @(posedge clock);
      #1;
      bus.go = 1'b0;
   endtask

   task automatic drain();
      int i = 0;
      while (sb.size() != 0 && i < 20) begin
         @(negedge clock);
         i++;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);
      repeat (2) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nbusy;
      bus.go  = 1'b0;
      bus.clr = 1'b0;
      bus.f   = 3'b000;
      bus.a   = '0;
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_acc", 32'(bus.acc), 32'h0);
      chk("rst_carry", 32'(bus.carry), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_zero", 32'(bus.zero), 32'h1);
      @(posedge clock);
      #1 reset_n = 1'b1;

      // Reset in the middle of a multiply
      issue(OP_INC, 4'h2, 1'b1, 8'h03, 1'b0);
      drain();
`ifdef ACC_ALU_MUL_EN
      issue(OP_MUL, 4'hF, 1'b0, 8'h00, 1'b0);
      @(negedge clock);
      chk("mulrst_busy_before", 32'(bus.busy), 32'h1);
      chk("mulrst_acc_hold", 32'(bus.acc), 32'h03);
`else
      issue(OP_MUL, 4'hF, 1'b1, 8'h03, 1'b0);
      @(negedge clock);
      chk("mulrst_busy_before", 32'(bus.busy), 32'h0);
`endif
      @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      chk("async_rst_acc", 32'(bus.acc), 32'h0);
      chk("async_rst_busy", 32'(bus.busy), 32'h0);
      chk("async_rst_done", 32'(bus.done), 32'h0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (6) @(negedge clock);

      // Add with carry, then modular add
      issue(OP_INC,  4'h8, 1'b1, 8'h09, 1'b0);
      issue(OP_ADDC, 4'h8, 1'b1, 8'h11, 1'b1);
      issue(OP_ADD,  4'h8, 1'b1, 8'h09, 1'b1);
      drain();
      chk("zero_nonzero", 32'(bus.zero), 32'h0);

      // Shift bounds and logic ops
      issue(OP_INC,    4'h4, 1'b1, 8'h05, 1'b0);
      issue(OP_SHL,    4'h2, 1'b1, 8'h14, 1'b0);
      issue(OP_INC,    4'h4, 1'b1, 8'h05, 1'b0);
      issue(OP_SHL,    4'h8, 1'b1, 8'h00, 1'b0);
      issue(OP_INC,    4'h4, 1'b1, 8'h05, 1'b0);
      issue(OP_SHR,    4'h4, 1'b1, 8'h00, 1'b0);
      issue(OP_INC,    4'h4, 1'b1, 8'h05, 1'b0);
      issue(OP_SHL,    4'h7, 1'b1, 8'h80, 1'b0);
      issue(OP_INC,    4'h4, 1'b1, 8'h05, 1'b0);
      issue(OP_SHR,    4'h1, 1'b1, 8'h02, 1'b0);
      issue(OP_INC,    4'h4, 1'b1, 8'h05, 1'b0);
      issue(OP_XOR_OR, 4'h3, 1'b1, 8'h76, 1'b0);
      issue(OP_RED,    4'h0, 1'b1, 8'h01, 1'b0);
      issue(OP_SHR,    4'h4, 1'b1, 8'h00, 1'b0);
      issue(OP_RED,    4'h0, 1'b1, 8'h00, 1'b0);
      drain();
      chk("zero_on_zero", 32'(bus.zero), 32'h1);

      // Multiply timing; go and clr during MUL must be ignored
      issue(OP_INC, 4'hC, 1'b1, 8'h0D, 1'b0);
      drain();
`ifdef ACC_ALU_MUL_EN
      issue(OP_MUL, 4'hB, 1'b1, 8'h8F, 1'b0);
`else
      issue(OP_MUL, 4'hB, 1'b1, 8'h0D, 1'b0);
`endif
      nbusy = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (bus.busy === 1'b1) nbusy++;
         if (i == 0) chk("mul_acc_hold", 32'(bus.acc), 32'h0D);
         if (i == DONE_IDX) chk("mul_done_cycle", 32'(bus.done), 32'h1);
`ifdef ACC_ALU_MUL_EN
         if (i == 0) begin
            bus.go = 1'b1;
            bus.f  = OP_INC;
            bus.a  = 4'hF;
         end else if (i == 1) begin
            bus.go  = 1'b0;
            bus.clr = 1'b1;
         end else if (i == 2) begin
            bus.clr = 1'b0;
         end
`endif
      end
      chk("mul_busy_cycles", 32'(nbusy), 32'(MUL_BUSY));
      drain();

      // Back-to-back issue, then clr with go
      issue(OP_INC, 4'h1, 1'b1, 8'h02, 1'b0);
      issue(OP_INC, 4'hF, 1'b1, 8'h10, 1'b1);
      drain();
      chk("b2b_zero", 32'(bus.zero), 32'h0);
      bus.clr = 1'b1;
      bus.go  = 1'b1;
      bus.f   = OP_INC;
      bus.a   = 4'h3;
      @(posedge clock);
      #1;
      bus.clr = 1'b0;
      bus.go  = 1'b0;
      @(negedge clock);
      chk("clr_acc", 32'(bus.acc), 32'h0);
      chk("clr_carry", 32'(bus.carry), 32'h0);
      chk("clr_zero", 32'(bus.zero), 32'h1);
      chk("clr_no_done", 32'(bus.done), 32'h0);
      repeat (3) @(negedge clock);
      chk("sb_empty_end", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
